// File: rtl/core_pkg.sv
// Shared core definitions: write-data select codes, datapath widths, hazard FSM
// state and the register-match helper used by the forwarding muxes.
package core_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_IMM  = 2'd3;

  typedef enum logic [0:0] {
    StRun,
    StLuStall
  } lu_state_e;

  // A stage supplies an operand only for a live, non-x0 write to the register ID actually reads.
  function automatic logic src_match(input logic             we,
                                     input logic [REG_W-1:0] wr,
                                     input logic [REG_W-1:0] rs,
                                     input logic             re);
    return we && (wr != '0) && (wr == rs) && re;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-facing bundle of the hazard/forwarding controller: stage write-back
// info in, stall/flush controls, forwarded operands and perf counters out.
interface hazard_fwd_ctrl_if
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic              id_re1;
  logic              id_re2;
  logic [REG_W-1:0]  ex_wR;
  logic              ex_rf_we;
  logic [1:0]        ex_wd_sel;
  logic [DATA_W-1:0] ex_wD;
  logic [REG_W-1:0]  mem_wR;
  logic              mem_rf_we;
  logic [DATA_W-1:0] mem_wD;
  logic [REG_W-1:0]  wb_wR;
  logic              wb_rf_we;
  logic [DATA_W-1:0] wb_wD;
  logic              ex_redirect;

  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              rD1_op;
  logic              rD2_op;
  logic [DATA_W-1:0] rD1_f;
  logic [DATA_W-1:0] rD2_f;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_re1, id_re2,
    output ex_wR, ex_rf_we, ex_wd_sel, ex_wD,
    output mem_wR, mem_rf_we, mem_wD,
    output wb_wR, wb_rf_we, wb_wD,
    output ex_redirect,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    input  rD1_op, rD2_op, rD1_f, rD2_f,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_re1, id_re2,
    input  ex_wR, ex_rf_we, ex_wd_sel, ex_wD,
    input  mem_wR, mem_rf_we, mem_wD,
    input  wb_wR, wb_rf_we, wb_wD,
    input  ex_redirect,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    output rD1_op, rD2_op, rD1_f, rD2_f,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_mux.sv
// Per-operand forwarding select: EX > MEM > WB priority, with an EX load hit
// reported as a load-use hazard instead of being forwarded.
module fwd_mux
  import core_pkg::*;
(
  input  logic [REG_W-1:0]  rs,
  input  logic              re,
  input  logic [REG_W-1:0]  ex_wr,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_wd,
  input  logic [REG_W-1:0]  mem_wr,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic [REG_W-1:0]  wb_wr,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              op,
  output logic [DATA_W-1:0] data,
  output logic              lu_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = src_match(ex_we,  ex_wr,  rs, re);
  assign mem_hit = src_match(mem_we, mem_wr, rs, re);
  assign wb_hit  = src_match(wb_we,  wb_wr,  rs, re);

  always_comb begin
    op     = 1'b0;
    data   = '0;
    lu_hit = 1'b0;
    if (ex_hit) begin
      // Load data is not ready in EX; older stages hold stale values, so nothing is forwarded.
      if (ex_is_load) begin
        lu_hit = 1'b1;
      end else begin
        op   = 1'b1;
        data = ex_wd;
      end
    end else if (mem_hit) begin
      op   = 1'b1;
      data = mem_wd;
    end else if (wb_hit) begin
      op   = 1'b1;
      data = wb_wd;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: operand forwarding, load-use bubble FSM,
// branch/jump redirect flushes and saturating stall/flush event counters.
module hazard_fwd_ctrl
  import core_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_ctrl_if.slave  bus
);

  localparam logic [1:0] LuCntInit = 2'(LU_STALL_CYCLES - 1);

  logic      lu1;
  logic      lu2;
  logic      lu;
  logic      ex_is_load;
  logic      stall;
  logic      redirect;

  lu_state_e        state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign ex_is_load = (bus.ex_wd_sel == WD_DRAM);
  assign redirect   = bus.ex_redirect;

  fwd_mux u_fwd_rs1 (
    .rs         (bus.id_rs1),
    .re         (bus.id_re1),
    .ex_wr      (bus.ex_wR),
    .ex_we      (bus.ex_rf_we),
    .ex_is_load (ex_is_load),
    .ex_wd      (bus.ex_wD),
    .mem_wr     (bus.mem_wR),
    .mem_we     (bus.mem_rf_we),
    .mem_wd     (bus.mem_wD),
    .wb_wr      (bus.wb_wR),
    .wb_we      (bus.wb_rf_we),
    .wb_wd      (bus.wb_wD),
    .op         (bus.rD1_op),
    .data       (bus.rD1_f),
    .lu_hit     (lu1)
  );

  fwd_mux u_fwd_rs2 (
    .rs         (bus.id_rs2),
    .re         (bus.id_re2),
    .ex_wr      (bus.ex_wR),
    .ex_we      (bus.ex_rf_we),
    .ex_is_load (ex_is_load),
    .ex_wd      (bus.ex_wD),
    .mem_wr     (bus.mem_wR),
    .mem_we     (bus.mem_rf_we),
    .mem_wd     (bus.mem_wD),
    .wb_wr      (bus.wb_wR),
    .wb_we      (bus.wb_rf_we),
    .wb_wd      (bus.wb_wD),
    .op         (bus.rD2_op),
    .data       (bus.rD2_f),
    .lu_hit     (lu2)
  );

  assign lu = lu1 | lu2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the bubbles still owed after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      state_d = StRun;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu && (LU_STALL_CYCLES > 1)) begin
            state_d = StLuStall;
            cnt_d   = LuCntInit;
          end
        end
        StLuStall: begin
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Redirect overrides any bubble so the PC can load the branch target.
  always_comb begin
    stall = 1'b0;
    if (!redirect) begin
      unique case (state_q)
        StRun:     stall = lu;
        StLuStall: stall = 1'b1;
        default:   stall = 1'b0;
      endcase
    end
  end

  assign bus.stall_pc    = stall;
  assign bus.stall_if_id = stall;
  assign bus.flush_if_id = redirect;
  assign bus.flush_id_ex = stall | redirect;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench: three controllers (LU_STALL_CYCLES = 1, 2, 3) share one
// stimulus set; each scenario checks the instance it targets.
module tb_hazard_fwd_ctrl;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic [4:0]  id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
  logic        id_re1, id_re2, ex_rf_we, mem_rf_we, wb_rf_we, ex_redirect;
  logic [1:0]  ex_wd_sel;
  logic [31:0] ex_wD, mem_wD, wb_wD;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_fwd_ctrl_if #(.CNT_W(32)) u_bus ();

    assign u_bus.id_rs1      = id_rs1;
    assign u_bus.id_rs2      = id_rs2;
    assign u_bus.id_re1      = id_re1;
    assign u_bus.id_re2      = id_re2;
    assign u_bus.ex_wR       = ex_wR;
    assign u_bus.ex_rf_we    = ex_rf_we;
    assign u_bus.ex_wd_sel   = ex_wd_sel;
    assign u_bus.ex_wD       = ex_wD;
    assign u_bus.mem_wR      = mem_wR;
    assign u_bus.mem_rf_we   = mem_rf_we;
    assign u_bus.mem_wD      = mem_wD;
    assign u_bus.wb_wR       = wb_wR;
    assign u_bus.wb_rf_we    = wb_rf_we;
    assign u_bus.wb_wD       = wb_wD;
    assign u_bus.ex_redirect = ex_redirect;

    hazard_fwd_ctrl #(
      .LU_STALL_CYCLES (g + 1),
      .CNT_W           (32)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_bus.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    id_rs1 = '0; id_rs2 = '0; id_re1 = 1'b0; id_re2 = 1'b0;
    ex_wR = '0; ex_rf_we = 1'b0; ex_wd_sel = WD_ALU; ex_wD = '0;
    mem_wR = '0; mem_rf_we = 1'b0; mem_wD = '0;
    wb_wR = '0; wb_rf_we = 1'b0; wb_wD = '0;
    ex_redirect = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic ex_load_x7();
    ex_wR = 5'd7; ex_rf_we = 1'b1; ex_wd_sel = WD_DRAM; ex_wD = 32'hBAD;
    id_rs1 = 5'd7; id_re1 = 1'b1;
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    #3;
    check("rst_stall_pc",    g_dut[0].u_bus.stall_pc,    32'd0);
    check("rst_flush_id_ex", g_dut[0].u_bus.flush_id_ex, 32'd0);
    check("rst_rD1_op",      g_dut[0].u_bus.rD1_op,      32'd0);
    check("rst_rD1_f",       g_dut[0].u_bus.rD1_f,       32'd0);
    check("rst_stall_cnt",   g_dut[0].u_bus.stall_cnt,   32'd0);
    check("rst_flush_cnt",   g_dut[0].u_bus.flush_cnt,   32'd0);
    do_reset();

    // EX beats MEM for the same register.
    ex_wR = 5'd5; ex_rf_we = 1'b1; ex_wD = 32'h11;
    mem_wR = 5'd5; mem_rf_we = 1'b1; mem_wD = 32'h22;
    id_rs1 = 5'd5; id_re1 = 1'b1;
    #1;
    check("ex_over_mem_op", g_dut[0].u_bus.rD1_op,   32'd1);
    check("ex_over_mem_f",  g_dut[0].u_bus.rD1_f,    32'h11);
    check("ex_fwd_nostall", g_dut[0].u_bus.stall_pc, 32'd0);
    id_re1 = 1'b0;
    #1;
    check("re1_off_op", g_dut[0].u_bus.rD1_op, 32'd0);

    clr_inputs();
    mem_wR = 5'd6; mem_rf_we = 1'b1; mem_wD = 32'h33;
    wb_wR = 5'd6; wb_rf_we = 1'b1; wb_wD = 32'h44;
    id_rs2 = 5'd6; id_re2 = 1'b1;
    #1;
    check("mem_over_wb_op", g_dut[0].u_bus.rD2_op, 32'd1);
    check("mem_over_wb_f",  g_dut[0].u_bus.rD2_f,  32'h33);
    mem_wR = 5'd0;
    #1;
    check("wb_fwd_f", g_dut[0].u_bus.rD2_f, 32'h44);
    wb_wR = 5'd0;
    #1;
    check("x0_nofwd_op", g_dut[0].u_bus.rD2_op, 32'd0);
    check("x0_nofwd_f",  g_dut[0].u_bus.rD2_f,  32'd0);

    // Load-use: instance 0 has 1 bubble, instance 1 has 2.
    do_reset();
    ex_load_x7();
    #1;
    check("lu1_stall_pc",    g_dut[0].u_bus.stall_pc,    32'd1);
    check("lu1_stall_if_id", g_dut[0].u_bus.stall_if_id, 32'd1);
    check("lu1_flush_id_ex", g_dut[0].u_bus.flush_id_ex, 32'd1);
    check("lu1_flush_if_id", g_dut[0].u_bus.flush_if_id, 32'd0);
    check("lu1_no_fwd",      g_dut[0].u_bus.rD1_op,      32'd0);
    cyc();
    ex_rf_we = 1'b0; ex_wd_sel = WD_ALU; ex_wR = '0;
    mem_wR = 5'd7; mem_rf_we = 1'b1; mem_wD = 32'hDEAD;
    #1;
    check("lu1_resume",     g_dut[0].u_bus.stall_pc,  32'd0);
    check("lu1_mem_op",     g_dut[0].u_bus.rD1_op,    32'd1);
    check("lu1_mem_f",      g_dut[0].u_bus.rD1_f,     32'hDEAD);
    check("lu1_stall_cnt",  g_dut[0].u_bus.stall_cnt, 32'd1);
    check("lu2_bubble2",    g_dut[1].u_bus.stall_pc,  32'd1);
    check("lu2_bubble2_fl", g_dut[1].u_bus.flush_id_ex, 32'd1);
    cyc();
    mem_rf_we = 1'b0; mem_wR = '0; mem_wD = '0;
    wb_wR = 5'd7; wb_rf_we = 1'b1; wb_wD = 32'hDEAD;
    #1;
    check("lu2_resume",    g_dut[1].u_bus.stall_pc,  32'd0);
    check("lu2_wb_op",     g_dut[1].u_bus.rD1_op,    32'd1);
    check("lu2_wb_f",      g_dut[1].u_bus.rD1_f,     32'hDEAD);
    check("lu2_stall_cnt", g_dut[1].u_bus.stall_cnt, 32'd2);
    check("lu1_cnt_held",  g_dut[0].u_bus.stall_cnt, 32'd1);

    // Redirect in the same cycle as a load-use hazard.
    do_reset();
    ex_load_x7();
    ex_redirect = 1'b1;
    #1;
    check("rd_flush_if_id", g_dut[1].u_bus.flush_if_id, 32'd1);
    check("rd_flush_id_ex", g_dut[1].u_bus.flush_id_ex, 32'd1);
    check("rd_stall_pc",    g_dut[1].u_bus.stall_pc,    32'd0);
    check("rd_stall_if_id", g_dut[1].u_bus.stall_if_id, 32'd0);
    cyc();
    clr_inputs();
    #1;
    check("rd_fsm_run",    g_dut[1].u_bus.stall_pc,  32'd0);
    check("rd_flush_cnt",  g_dut[1].u_bus.flush_cnt, 32'd1);
    check("rd_stall_cnt",  g_dut[1].u_bus.stall_cnt, 32'd0);

    // Reset asserted during the second of three bubbles.
    do_reset();
    ex_load_x7();
    #1;
    check("lu3_bubble1", g_dut[2].u_bus.stall_pc, 32'd1);
    cyc();
    ex_rf_we = 1'b0; ex_wd_sel = WD_ALU; ex_wR = '0;
    #1;
    check("lu3_bubble2", g_dut[2].u_bus.stall_pc,  32'd1);
    check("lu3_cnt_pre", g_dut[2].u_bus.stall_cnt, 32'd1);
    rst_n = 1'b0;
    #1;
    check("lu3_rst_async_stall", g_dut[2].u_bus.stall_pc,  32'd0);
    check("lu3_rst_async_cnt",   g_dut[2].u_bus.stall_cnt, 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("lu3_post_stall_pc",  g_dut[2].u_bus.stall_pc,  32'd0);
    check("lu3_post_stall_cnt", g_dut[2].u_bus.stall_cnt, 32'd0);
    check("lu3_post_flush_cnt", g_dut[2].u_bus.flush_cnt, 32'd0);
    cyc();
    check("lu3_no_residual", g_dut[2].u_bus.stall_pc,  32'd0);
    check("lu3_cnt_still0",  g_dut[2].u_bus.stall_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
